// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds the UART core's transmit data register over its bus write port,
// pacing each write on the UDRE (txir) flag and guarding against double writes on one UDRE level.
module uart_tx_feeder #(
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  UDR_ADDR  = 8'hC6,
    parameter int          SETTLE_TO = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    input  logic                       u_txir,
    output logic [7:0]                 u_addr,
    output logic [7:0]                 u_din,
    output logic                       u_write,
    output logic                       busy,
    output logic                       settle_err,
    output logic [1:0]                 state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(SETTLE_TO+1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_WRITE  = 2'd2,
        S_SETTLE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [7:0]      u_addr_q, u_addr_d;
    logic [7:0]      u_din_q, u_din_d;
    logic            u_write_q, u_write_d;
    logic [7:0]      fifo_mem [DEPTH];
    logic            push;
    logic            pop;

    // Producer handshake: a byte transfers on a clock edge where in_valid && in_ready,
    // unless flush is high in that same cycle (the byte is then discarded).
    assign push = in_valid && in_ready_q && !flush;
    assign pop  = (state_q == S_WRITE) && !flush;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (count_q != '0)) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)     state_d = S_IDLE;
                else if (u_txir) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d      = S_SETTLE;
                settle_cnt_d = '0;
            end
            S_SETTLE: begin
                // UDRE must drop after our write before another write is allowed
                if (!u_txir) begin
                    state_d = S_IDLE;
                end else if (settle_cnt_q == SW'(SETTLE_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            err_d = 1'b0;
            if (state_q != S_WRITE) state_d = S_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        in_ready_d = (count_d != CW'(DEPTH));
        busy_d     = (state_d != S_IDLE) || (count_d != '0);
    end

    // The bus cycle is registered off the WRITE state, so the strobe lands in the first SETTLE cycle
    always_comb begin
        u_write_d = (state_q == S_WRITE);
        u_addr_d  = u_write_d ? UDR_ADDR : 8'h00;
        u_din_d   = u_write_d ? fifo_mem[rd_ptr_q] : u_din_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            settle_cnt_q <= '0;
            u_addr_q     <= 8'h00;
            u_din_q      <= 8'h00;
            u_write_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            settle_cnt_q <= settle_cnt_d;
            u_addr_q     <= u_addr_d;
            u_din_q      <= u_din_d;
            u_write_q    <= u_write_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_data;
    end

    assign in_ready   = in_ready_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign settle_err = err_q;
    assign u_addr     = u_addr_q;
    assign u_din      = u_din_q;
    assign u_write    = u_write_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: per-cycle vector table for the basic flow, then hand-written
// sequences for reset, backpressure, full/simultaneous push-pop, settle timeout, flush and enable.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [4:0] fifo_count;
  logic       u_txir;
  logic [7:0] u_addr;
  logic [7:0] u_din;
  logic       u_write;
  logic       busy;
  logic       settle_err;
  logic [1:0] state_dbg;

  int         n_vec = 0;
  int         n_miss = 0;
  int         write_cnt = 0;
  int         hold = 0;
  int         w0;
  logic       mon_en = 1'b0;
  logic       uart_auto = 1'b0;
  logic       txir_drv = 1'b0;
  logic       model_txir = 1'b1;
  logic       ok;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       en;
    logic       fl;
    logic       vld;
    logic [7:0] data;
    logic       txir;
    logic       uw;
    logic [7:0] addr;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       rdy;
    logic       bsy;
    logic       err;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[16];

  assign u_txir = uart_auto ? model_txir : txir_drv;

  uart_tx_feeder #(.DEPTH(16), .UDR_ADDR(8'hC6), .SETTLE_TO(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_count (fifo_count),
    .u_txir     (u_txir),
    .u_addr     (u_addr),
    .u_din      (u_din),
    .u_write    (u_write),
    .busy       (busy),
    .settle_err (settle_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART model: clears UDRE on a write, sets it again a couple of cycles later
  always @(negedge clk) begin
    if (u_write) begin
      model_txir = 1'b0;
      hold = 2;
    end else if (hold > 0) begin
      hold = hold - 1;
    end else begin
      model_txir = 1'b1;
    end
  end

  // scoreboard on the bus side
  always @(negedge clk) begin
    if (rst && u_write) begin
      write_cnt++;
      if (mon_en) begin
        check("u_addr on write", {24'h0, u_addr}, 32'hC6);
        if (exp_q.size() == 0) check("spurious u_write", 1, 0);
        else check("u_din order", {24'h0, u_din}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic push(input logic [7:0] d);
    logic acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    acc = in_ready && !flush;
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_write(input string name, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (u_write) found = 1'b1;
    end
    if (!found) check({name, " write timeout"}, 0, 1);
  endtask

  task automatic wait_state(input string name, input logic [1:0] st);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (state_dbg == st) found = 1'b1;
    end
    if (!found) check({name, " state timeout"}, 0, 1);
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    uart_auto = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check({name, " drained"}, {31'h0, done}, 1);
    check({name, " count after drain"}, {27'h0, fifo_count}, 0);
    uart_auto = 1'b0;
  endtask

  initial begin
    //            en    fl    vld   data   txir  | uw    addr   din    cnt   rdy   bsy   err   st
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 5'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 5'd1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 5'd1, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC6, 8'hA5, 5'd0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC6, 8'h3C, 5'd0, 1'b1, 1'b1, 1'b0, 2'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 8'h00, 8'h3C, 5'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0};

    rst = 1'b0; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("reset u_write", {31'h0, u_write}, 0);
    check("reset u_addr", {24'h0, u_addr}, 0);
    check("reset u_din", {24'h0, u_din}, 0);
    check("reset count", {27'h0, fifo_count}, 0);
    check("reset in_ready", {31'h0, in_ready}, 1);
    check("reset busy", {31'h0, busy}, 0);
    check("reset settle_err", {31'h0, settle_err}, 0);
    check("reset state", {30'h0, state_dbg}, 0);
    rst = 1'b1;

    // per-cycle vectors: single byte, enable gating, flush versus push
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      enable = vecs[i].en; flush = vecs[i].fl; in_valid = vecs[i].vld;
      in_data = vecs[i].data; txir_drv = vecs[i].txir;
      @(posedge clk);
      #1;
      check($sformatf("v%0d u_write", i), {31'h0, u_write}, {31'h0, vecs[i].uw});
      check($sformatf("v%0d u_addr", i), {24'h0, u_addr}, {24'h0, vecs[i].addr});
      check($sformatf("v%0d u_din", i), {24'h0, u_din}, {24'h0, vecs[i].din});
      check($sformatf("v%0d count", i), {27'h0, fifo_count}, {27'h0, vecs[i].cnt});
      check($sformatf("v%0d in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].rdy});
      check($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].bsy});
      check($sformatf("v%0d settle_err", i), {31'h0, settle_err}, {31'h0, vecs[i].err});
      check($sformatf("v%0d state", i), {30'h0, state_dbg}, {30'h0, vecs[i].st});
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; txir_drv = 1'b0;
    mon_en = 1'b1;

    // asynchronous reset while a write is on the bus with bytes still queued
    enable = 1'b1; txir_drv = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    wait_write("rst", ok);
    #1;
    rst = 1'b0;
    #1;
    check("rst mid u_write", {31'h0, u_write}, 0);
    check("rst mid count", {27'h0, fifo_count}, 0);
    check("rst mid in_ready", {31'h0, in_ready}, 1);
    check("rst mid busy", {31'h0, busy}, 0);
    check("rst mid state", {30'h0, state_dbg}, 0);
    exp_q.delete();
    txir_drv = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // fill to full under backpressure, then drain in order
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("full count", {27'h0, fifo_count}, 16);
    check("full in_ready", {31'h0, in_ready}, 0);
    push(8'h99);
    check("push to full ignored", {27'h0, fifo_count}, 16);
    w0 = write_cnt;
    drain("order");
    check("order write count", write_cnt - w0, 16);

    // pop from full while producer holds a byte: accepted one cycle later
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    @(negedge clk);
    txir_drv = 1'b1; in_valid = 1'b1; in_data = 8'h40;
    wait_state("full pop", 2'd2);
    check("write state count", {27'h0, fifo_count}, 16);
    check("write state in_ready", {31'h0, in_ready}, 0);
    txir_drv = 1'b0;
    @(posedge clk);
    #1;
    check("after pop u_write", {31'h0, u_write}, 1);
    check("after pop count", {27'h0, fifo_count}, 15);
    check("after pop in_ready", {31'h0, in_ready}, 1);
    exp_q.push_back(8'h40);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("refill count", {27'h0, fifo_count}, 16);
    check("refill in_ready", {31'h0, in_ready}, 0);
    do_flush();
    check("flush full count", {27'h0, fifo_count}, 0);

    // push and pop on the same edge at count 5
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    @(negedge clk);
    txir_drv = 1'b1;
    wait_state("simul", 2'd2);
    in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk);
    exp_q.push_back(8'h55);
    #1;
    in_valid = 1'b0; txir_drv = 1'b0;
    check("push+pop count", {27'h0, fifo_count}, 5);
    drain("simul");

    // settle timeout: UDRE never drops after the write
    txir_drv = 1'b1;
    push(8'h66);
    wait_write("settle", ok);
    repeat (58) @(posedge clk);
    #1;
    check("settle_err before timeout", {31'h0, settle_err}, 0);
    check("still in settle", {30'h0, state_dbg}, 3);
    repeat (7) @(posedge clk);
    #1;
    check("settle_err after timeout", {31'h0, settle_err}, 1);
    check("idle after timeout", {30'h0, state_dbg}, 0);
    do_flush();
    check("flush clears settle_err", {31'h0, settle_err}, 0);
    txir_drv = 1'b0;

    // flush while waiting for UDRE discards everything
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    @(posedge clk);
    #1;
    check("wait before flush", {30'h0, state_dbg}, 1);
    check("count before flush", {27'h0, fifo_count}, 4);
    do_flush();
    check("count after flush", {27'h0, fifo_count}, 0);
    check("idle after flush", {30'h0, state_dbg}, 0);
    w0 = write_cnt;
    txir_drv = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no write after flush", write_cnt - w0, 0);
    txir_drv = 1'b0;

    // enable dropped in SETTLE: current write completes, nothing further
    push(8'h80); push(8'h81);
    txir_drv = 1'b1;
    wait_write("enable", ok);
    check("enable write data", {24'h0, u_din}, 32'h80);
    enable = 1'b0; txir_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("enable off idle", {30'h0, state_dbg}, 0);
    check("enable off count", {27'h0, fifo_count}, 1);
    w0 = write_cnt;
    txir_drv = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("enable off no write", write_cnt - w0, 0);
    check("enable off hold", {27'h0, fifo_count}, 1);
    enable = 1'b1;
    drain("enable");
    check("enable resume writes", write_cnt - w0, 1);
    check("scoreboard empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
